loopback_stim_checker: RTL and testbench



---
 rtl/loopback_stim_checker_pkg.sv | 19 +
 rtl/loopback_stim_checker_lfsr8_serial.sv | 36 +++
 rtl/loopback_stim_checker.sv | 153 +++++++++++++++
 tb/tb_loopback_stim_checker.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loopback_stim_checker_pkg.sv
// rtl/loopback_stim_checker_pkg.sv - shared state type and LFSR step for the loopback checker
package loopback_stim_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int LFSR_W = 8;
    // Feedback taps at bits 0, 2, 3 and 4; the register shifts right.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'h1D;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/loopback_stim_checker_lfsr8_serial.sv
// rtl/loopback_stim_checker_lfsr8_serial.sv - 8-bit LFSR with load/enable and serial bit output
module lfsr8_serial
    import loopback_stim_checker_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic bit_o
);

    logic [LFSR_W-1:0] state_q;
    logic [LFSR_W-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = SEED;
        end else if (en_i) begin
            state_d = lfsr_next(state_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign bit_o = state_q[0];

endmodule

// File: rtl/loopback_stim_checker.sv
// rtl/loopback_stim_checker.sv - drives an LFSR bit stream and checks its echo after a fixed latency
module loopback_stim_checker
    import loopback_stim_checker_pkg::*;
#(
    parameter int                LEN_W = 16,
    parameter int                LAT   = 0,
    parameter logic [LFSR_W-1:0] SEED  = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] length,
    output logic             drive,
    input  logic             observe,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [LEN_W-1:0] err_count,
    output logic [LEN_W-1:0] first_err_idx
);

    localparam logic [LEN_W-1:0] ALL_ONES = '1;
    localparam logic [LEN_W-1:0] ONE      = 1;

    if (SEED == '0) begin : g_bad_seed
        $error("loopback_stim_checker: SEED must be nonzero");
    end
    if (LAT < 0 || LAT > 7) begin : g_bad_lat
        $error("loopback_stim_checker: LAT must be within 0..7");
    end

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] err_q, err_d;
    logic [LEN_W-1:0] first_q, first_d;
    logic [2:0]       drain_q, drain_d;
    logic             pass_q, pass_d;
    logic             lfsr_load, lfsr_en, lfsr_bit;
    logic             cmp_valid, cmp_exp;
    logic [LEN_W-1:0] cmp_idx;

    lfsr8_serial #(.SEED(SEED)) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load_i (lfsr_load),
        .en_i   (lfsr_en),
        .bit_o  (lfsr_bit)
    );

    // With no latency the echo is checked in the same cycle the bit is driven.
    if (LAT == 0) begin : g_direct
        assign cmp_valid = (state_q == ST_RUN);
        assign cmp_exp   = lfsr_bit;
        assign cmp_idx   = idx_q;
    end else begin : g_delay
        typedef struct packed {
            logic             vld;
            logic             exp;
            logic [LEN_W-1:0] idx;
        } dl_t;
        dl_t dl_q [LAT];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < LAT; i++) dl_q[i] <= '0;
            end else begin
                dl_q[0] <= '{vld: (state_q == ST_RUN), exp: lfsr_bit, idx: idx_q};
                for (int i = 1; i < LAT; i++) dl_q[i] <= dl_q[i-1];
            end
        end

        assign cmp_valid = dl_q[LAT-1].vld;
        assign cmp_exp   = dl_q[LAT-1].exp;
        assign cmp_idx   = dl_q[LAT-1].idx;
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        err_d     = err_q;
        first_d   = first_q;
        drain_d   = drain_q;
        pass_d    = pass_q;
        lfsr_load = 1'b0;
        lfsr_en   = 1'b0;

        if (cmp_valid && (observe != cmp_exp)) begin
            if (err_q != ALL_ONES) err_d = err_q + ONE;
            if (first_q == ALL_ONES) first_d = cmp_idx;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d     = length;
                    idx_d     = '0;
                    lfsr_load = 1'b1;
                    err_d     = '0;
                    first_d   = ALL_ONES;
                    pass_d    = 1'b0;
                    state_d   = (length == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                lfsr_en = 1'b1;
                idx_d   = idx_q + ONE;
                if (idx_q == len_q - ONE) begin
                    drain_d = '0;
                    state_d = (LAT > 0) ? ST_DRAIN : ST_DONE;
                end
            end
            ST_DRAIN: begin
                drain_d = drain_q + 3'd1;
                if (drain_q == 3'(LAT - 1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                pass_d  = (err_q == '0);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            err_q   <= '0;
            first_q <= ALL_ONES;
            drain_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            first_q <= first_d;
            drain_q <= drain_d;
            pass_q  <= pass_d;
        end
    end

    assign drive         = (state_q == ST_RUN) & lfsr_bit;
    assign busy          = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done          = (state_q == ST_DONE);
    assign pass          = done ? (err_q == '0) : pass_q;
    assign err_count     = err_q;
    assign first_err_idx = first_q;

endmodule

// File: tb/tb_loopback_stim_checker.sv
// tb/tb_loopback_stim_checker.sv - scoreboard bench for loopback_stim_checker at latencies 0, 1 and 2
module tb_loopback_stim_checker;
    import loopback_stim_checker_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start0, start1, start2;
    logic [W-1:0] len0, len1, len2;
    logic         drv0, drv1, drv2, obs0, obs1, obs2;
    logic         busy0, busy1, busy2, done0, done1, done2, pass0, pass1, pass2;
    logic [W-1:0] err0, err1, err2, first0, first1, first2;
    int           mode0 = 0;
    logic [1:0]   d1_q, d2_q;

    int total = 0;
    int bad   = 0;
    logic exp_q[$];

    always_comb begin
        case (mode0)
            0:       obs0 = drv0;
            1:       obs0 = ~drv0;
            2:       obs0 = 1'b1;
            default: obs0 = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d1_q <= '0;
            d2_q <= '0;
        end else begin
            d1_q <= {d1_q[0], drv1};
            d2_q <= {d2_q[0], drv2};
        end
    end
    assign obs1 = d1_q[1];
    assign obs2 = d2_q[1];

    loopback_stim_checker #(.LEN_W(W), .LAT(0), .SEED(8'hA5)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .length(len0), .drive(drv0), .observe(obs0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .first_err_idx(first0));
    loopback_stim_checker #(.LEN_W(W), .LAT(1), .SEED(8'hA5)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .length(len1), .drive(drv1), .observe(obs1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_err_idx(first1));
    loopback_stim_checker #(.LEN_W(W), .LAT(2), .SEED(8'hA5)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .length(len2), .drive(drv2), .observe(obs2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .first_err_idx(first2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_bits(input int n);
        logic [7:0] s;
        s = 8'hA5;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(s[0]);
            s = lfsr_next(s);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick(); tick();
        total++;
        if (drv0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 || pass0 !== 1'b0 ||
            err0 !== 16'h0 || first0 !== 16'hFFFF || busy2 !== 1'b0) begin
            bad++;
            $display("FAIL reset drive=%b busy=%b done=%b pass=%b err=%h first=%h busy2=%b exp 0 0 0 0 0000 ffff 0",
                     drv0, busy0, done0, pass0, err0, first0, busy2);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_lat0_pattern(input int mode, input string name);
        logic         b, o;
        int           e_err;
        logic [W-1:0] e_first;
        mode0 = mode;
        exp_q.delete();
        push_bits(4);
        e_err   = 0;
        e_first = 16'hFFFF;
        foreach (exp_q[i]) begin
            b = exp_q[i];
            o = (mode == 0) ? b : (mode == 1) ? ~b : (mode == 2) ? 1'b1 : 1'b0;
            if (o !== b) begin
                if (e_first == 16'hFFFF) e_first = W'(i);
                e_err++;
            end
        end
        start0 = 1'b1; len0 = 16'd4;
        tick();
        start0 = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            b = exp_q.pop_front();
            total++;
            if (drv0 !== b || busy0 !== 1'b1 || done0 !== 1'b0) begin
                bad++;
                $display("FAIL %s cycle%0d drive=%b busy=%b done=%b exp drive=%b busy=1 done=0",
                         name, c, drv0, busy0, done0, b);
            end
            tick();
        end
        total++;
        if (done0 !== 1'b1 || pass0 !== (e_err == 0) || err0 !== W'(e_err) || first0 !== e_first) begin
            bad++;
            $display("FAIL %s done done=%b pass=%b err=%0d first=%h exp 1 %b %0d %h",
                     name, done0, pass0, err0, first0, (e_err == 0), e_err, e_first);
        end
        tick();
        total++;
        if (done0 !== 1'b0 || pass0 !== (e_err == 0) || err0 !== W'(e_err) || first0 !== e_first) begin
            bad++;
            $display("FAIL %s hold done=%b pass=%b err=%0d first=%h exp 0 %b %0d %h",
                     name, done0, pass0, err0, first0, (e_err == 0), e_err, e_first);
        end
        mode0 = 0;
    endtask

    task automatic test_lat2();
        logic eb;
        exp_q.delete();
        push_bits(8);
        start2 = 1'b1; len2 = 16'd8;
        tick();
        start2 = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            eb = (c <= 8) ? exp_q.pop_front() : 1'b0;
            total++;
            if (busy2 !== 1'b1 || done2 !== 1'b0 || drv2 !== eb) begin
                bad++;
                $display("FAIL lat2 cycle%0d busy=%b done=%b drive=%b exp busy=1 done=0 drive=%b",
                         c, busy2, done2, drv2, eb);
            end
            tick();
        end
        total++;
        if (done2 !== 1'b1 || busy2 !== 1'b0 || pass2 !== 1'b1 || err2 !== 16'h0 || first2 !== 16'hFFFF) begin
            bad++;
            $display("FAIL lat2 done done=%b busy=%b pass=%b err=%0d first=%h exp 1 0 1 0 ffff",
                     done2, busy2, pass2, err2, first2);
        end
        tick();
    endtask

    task automatic test_lat1_mismatch();
        logic prev;
        int   e_err;
        exp_q.delete();
        push_bits(8);
        // The 2-flop echo lags a 1-deep checker by one bit: bit k meets bit k-1.
        prev  = 1'b0;
        e_err = 0;
        foreach (exp_q[i]) begin
            if (exp_q[i] !== prev) e_err++;
            prev = exp_q[i];
        end
        start1 = 1'b1; len1 = 16'd8;
        tick();
        start1 = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            total++;
            if (busy1 !== 1'b1 || done1 !== 1'b0) begin
                bad++;
                $display("FAIL lat1 cycle%0d busy=%b done=%b exp busy=1 done=0", c, busy1, done1);
            end
            tick();
        end
        total++;
        if (done1 !== 1'b1 || pass1 !== 1'b0 || err1 !== W'(e_err) || err1 == 16'h0 || first1 !== 16'h0) begin
            bad++;
            $display("FAIL lat1 done done=%b pass=%b err=%0d first=%h exp 1 0 %0d 0000",
                     done1, pass1, err1, first1, e_err);
        end
        tick();
    endtask

    task automatic test_zero_length();
        start0 = 1'b1; len0 = 16'd0;
        tick();
        start0 = 1'b0;
        total++;
        if (done0 !== 1'b1 || busy0 !== 1'b0 || pass0 !== 1'b1 || err0 !== 16'h0 || first0 !== 16'hFFFF) begin
            bad++;
            $display("FAIL zero_len done=%b busy=%b pass=%b err=%0d first=%h exp 1 0 1 0 ffff",
                     done0, busy0, pass0, err0, first0);
        end
        tick();
        total++;
        if (done0 !== 1'b0 || busy0 !== 1'b0) begin
            bad++;
            $display("FAIL zero_len_after done=%b busy=%b exp 0 0", done0, busy0);
        end
    endtask

    task automatic test_start_ignored();
        logic b;
        exp_q.delete();
        push_bits(8);
        start0 = 1'b1; len0 = 16'd8;
        tick();
        start0 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            b = exp_q.pop_front();
            total++;
            if (drv0 !== b || done0 !== 1'b0) begin
                bad++;
                $display("FAIL start_ignored cycle%0d drive=%b done=%b exp drive=%b done=0", c, drv0, done0, b);
            end
            if (c == 3) begin
                start0 = 1'b1; len0 = 16'd2;
            end
            tick();
            start0 = 1'b0;
        end
        total++;
        if (done0 !== 1'b1 || pass0 !== 1'b1 || err0 !== 16'h0) begin
            bad++;
            $display("FAIL start_ignored done=%b pass=%b err=%0d exp 1 1 0", done0, pass0, err0);
        end
        tick();
    endtask

    task automatic test_abort();
        int   dones;
        logic b;
        start0 = 1'b1; len0 = 16'd8;
        tick();
        start0 = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        total++;
        if (drv0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0 || err0 !== 16'h0 || first0 !== 16'hFFFF) begin
            bad++;
            $display("FAIL abort drive=%b busy=%b done=%b err=%0d first=%h exp 0 0 0 0 ffff",
                     drv0, busy0, done0, err0, first0);
        end
        rst   = 1'b0;
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (done0 === 1'b1) dones++;
        end
        total++;
        if (dones != 0) begin
            bad++;
            $display("FAIL abort_no_done pulses=%0d exp 0", dones);
        end
        exp_q.delete();
        push_bits(4);
        start0 = 1'b1; len0 = 16'd4;
        tick();
        start0 = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            b = exp_q.pop_front();
            total++;
            if (drv0 !== b) begin
                bad++;
                $display("FAIL abort_replay cycle%0d drive=%b exp %b", c, drv0, b);
            end
            tick();
        end
        total++;
        if (done0 !== 1'b1 || pass0 !== 1'b1) begin
            bad++;
            $display("FAIL abort_replay_done done=%b pass=%b exp 1 1", done0, pass0);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        len0 = '0; len1 = '0; len2 = '0;
        test_reset();
        test_lat0_pattern(0, "direct");
        test_lat0_pattern(1, "inverted");
        test_lat0_pattern(2, "stuck1");
        test_lat0_pattern(3, "stuck0");
        test_zero_length();
        test_lat2();
        test_lat1_mismatch();
        test_start_ignored();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
